// File: rtl/memwb_pipe_pkg.sv
// Shared types and constants for the MEM/WB delay-line pipeline register.
package memwb_pkg;

   localparam int DATA_W      = 64;
   localparam int INST_W      = 32;
   localparam int LAT_DEFAULT = 3;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // One delay-line slot: write-back control plus the payload it carries.
   typedef struct packed {
      logic              valid;
      logic              memToReg;
      logic              regWrite;
      logic [DATA_W-1:0] alu_out;
      logic [4:0]        rd_addr;
      logic [INST_W-1:0] inst;
   } memwb_slot_t;

endpackage

// File: rtl/memwb_pipe_if.sv
// MEM-stage entry, load-data return, pipeline control and write-back port bundle.
interface memwb_pipe_if #(
   parameter int DATA_W = 64,
   parameter int INST_W = 32
);

   logic              i_valid;
   logic              i_memToReg;
   logic              i_regWrite;
   logic [DATA_W-1:0] i_alu_out;
   logic [4:0]        i_rd_addr;
   logic [INST_W-1:0] i_inst;
   logic              i_d_valid_data;
   logic [DATA_W-1:0] i_memory_data;
   logic              i_stall;
   logic              i_flush;

   logic              o_valid;
   logic              o_memToReg;
   logic              o_regWrite;
   logic [DATA_W-1:0] o_alu_out;
   logic [4:0]        o_rd_addr;
   logic [INST_W-1:0] o_inst;
   logic              o_wb_en;
   logic [4:0]        o_wb_rd;
   logic [DATA_W-1:0] o_wb_data;
   logic              o_wait;
   logic              o_ld_overflow;

   // Upstream side: MEM stage, data memory and pipeline control.
   modport master (
      output i_valid, i_memToReg, i_regWrite, i_alu_out, i_rd_addr, i_inst,
             i_d_valid_data, i_memory_data, i_stall, i_flush,
      input  o_valid, o_memToReg, o_regWrite, o_alu_out, o_rd_addr, o_inst,
             o_wb_en, o_wb_rd, o_wb_data, o_wait, o_ld_overflow
   );

   // Pipeline-register side.
   modport slave (
      input  i_valid, i_memToReg, i_regWrite, i_alu_out, i_rd_addr, i_inst,
             i_d_valid_data, i_memory_data, i_stall, i_flush,
      output o_valid, o_memToReg, o_regWrite, o_alu_out, o_rd_addr, o_inst,
             o_wb_en, o_wb_rd, o_wb_data, o_wait, o_ld_overflow
   );

endinterface

// File: rtl/memwb_pipe_ld_buf.sv
// Single-entry load-data buffer with sticky overflow flag.
module memwb_ld_buf #(
   parameter int DATA_W = 64
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_capture,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_consume,
   input  logic              i_flush,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_overflow
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              full_q, full_d;
   logic              ovf_q,  ovf_d;

   // Capture wins over consume on the same edge; flush empties the buffer last.
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      ovf_d  = ovf_q;
      if (i_consume) begin
         full_d = 1'b0;
      end
      if (i_capture) begin
         data_d = i_data;
         full_d = 1'b1;
         if (full_q && !i_consume) begin
            ovf_d = 1'b1;
         end
      end
      if (i_flush) begin
         full_d = 1'b0;
      end
   end

   // Buffer state register; overflow is cleared only by reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_q <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
         ovf_q  <= ovf_d;
      end
   end

   assign o_data     = data_q;
   assign o_full     = full_q;
   assign o_overflow = ovf_q;

endmodule

// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register: LAT-deep delay line, load-data wait and resolved write port.
module memwb_pipe #(
   parameter int DATA_W = memwb_pkg::DATA_W,
   parameter int INST_W = memwb_pkg::INST_W,
   parameter int LAT    = memwb_pkg::LAT_DEFAULT
) (
   input logic         i_clk,
   input logic         i_rst,
   memwb_pipe_if.slave bus
);

   import memwb_pkg::*;

   localparam int unsigned OUT = LAT - 1;

   memwb_slot_t       slot_q [LAT];
   memwb_slot_t       slot_d [LAT];
   memwb_slot_t       in_slot;
   memwb_slot_t       out_slot;

   logic              advance;
   logic              out_wait;
   logic              consume;
   logic              ld_full;
   logic              ld_ovf;
   logic [DATA_W-1:0] ld_data;

   // Pack the incoming MEM-stage entry into a slot.
   always_comb begin
      in_slot          = '0;
      in_slot.valid    = bus.i_valid;
      in_slot.memToReg = bus.i_memToReg;
      in_slot.regWrite = bus.i_regWrite;
      in_slot.alu_out  = bus.i_alu_out;
      in_slot.rd_addr  = bus.i_rd_addr;
      in_slot.inst     = INST_W'(bus.i_inst);
   end

   assign out_slot = slot_q[OUT];

   // Wait depends only on registered state, never on inputs.
   assign out_wait = out_slot.valid & out_slot.memToReg & ~ld_full;
   assign advance  = ~bus.i_stall & ~out_wait;
   assign consume  = advance & out_slot.valid & out_slot.memToReg;

   // Shift on advance, otherwise hold; flush kills every valid bit regardless.
   always_comb begin
      slot_d[0] = advance ? in_slot : slot_q[0];
      for (int unsigned k = 1; k < LAT; k++) begin
         slot_d[k] = advance ? slot_q[k-1] : slot_q[k];
      end
      if (bus.i_flush) begin
         for (int unsigned k = 0; k < LAT; k++) begin
            slot_d[k].valid = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < LAT; g++) begin : g_slot
      // Delay-line slot register.
      always_ff @(posedge i_clk) begin
         if (i_rst) begin
            slot_q[g] <= '0;
         end else begin
            slot_q[g] <= slot_d[g];
         end
      end
   end

   memwb_ld_buf #(
      .DATA_W(DATA_W)
   ) u_ld_buf (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_capture (bus.i_d_valid_data),
      .i_data    (bus.i_memory_data),
      .i_consume (consume),
      .i_flush   (bus.i_flush),
      .o_data    (ld_data),
      .o_full    (ld_full),
      .o_overflow(ld_ovf)
   );

   assign bus.o_valid       = out_slot.valid;
   assign bus.o_memToReg    = out_slot.memToReg;
   assign bus.o_regWrite    = out_slot.regWrite;
   assign bus.o_alu_out     = out_slot.alu_out;
   assign bus.o_rd_addr     = out_slot.rd_addr;
   assign bus.o_inst        = out_slot.inst;
   assign bus.o_wait        = out_wait;
   assign bus.o_ld_overflow = ld_ovf;
   assign bus.o_wb_rd       = out_slot.rd_addr;
   assign bus.o_wb_en       = out_slot.valid & out_slot.regWrite &
                              (out_slot.rd_addr != REG_ZERO) & ~out_wait;
   assign bus.o_wb_data     = out_slot.memToReg ? ld_data : out_slot.alu_out;

endmodule

// File: tb/tb_memwb_pipe.sv
// Scoreboard bench for memwb_pipe with LAT=3.
module tb_memwb_pipe;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } wb_exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   wb_exp_t sb_q [$];

   memwb_pipe_if #(.DATA_W(64), .INST_W(32)) bus ();

   memwb_pipe #(.DATA_W(64), .INST_W(32), .LAT(3)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      bus.i_valid        = 1'b0;
      bus.i_memToReg     = 1'b0;
      bus.i_regWrite     = 1'b0;
      bus.i_alu_out      = '0;
      bus.i_rd_addr      = '0;
      bus.i_inst         = '0;
      bus.i_d_valid_data = 1'b0;
      bus.i_memory_data  = '0;
      bus.i_stall        = 1'b0;
      bus.i_flush        = 1'b0;
   endtask

   task automatic put(input logic ld, input logic [4:0] rd, input logic [63:0] alu);
      bus.i_valid    = 1'b1;
      bus.i_memToReg = ld;
      bus.i_regWrite = 1'b1;
      bus.i_alu_out  = alu;
      bus.i_rd_addr  = rd;
      bus.i_inst     = {27'h0, rd};
   endtask

   task automatic push(input logic [4:0] rd, input logic [63:0] data);
      wb_exp_t e;
      e.rd   = rd;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Each committed write-back (not a stall repeat) retires one scoreboard entry.
   always @(negedge clk) begin
      if (bus.o_wb_en === 1'b1 && bus.i_stall === 1'b0) begin
         check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            wb_exp_t e;
            e = sb_q.pop_front();
            check("sb_rd", 64'(bus.o_wb_rd), 64'(e.rd));
            check("sb_data", bus.o_wb_data, e.data);
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      idle();
      step();
      step();
      @(negedge clk);
      check("rst_valid", 64'(bus.o_valid), 64'd0);
      check("rst_wb_en", 64'(bus.o_wb_en), 64'd0);
      check("rst_wait", 64'(bus.o_wait), 64'd0);
      check("rst_wb_data", bus.o_wb_data, 64'd0);
      check("rst_ovf", 64'(bus.o_ld_overflow), 64'd0);
      rst = 1'b0;
      step();

      // ALU op: write-back visible in cycle 3 only.
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) begin
            put(1'b0, 5'd5, 64'h2A);
            push(5'd5, 64'h2A);
         end
         @(negedge clk);
         check("alu_wb_en", 64'(bus.o_wb_en), 64'(c == 3));
         if (c == 3) begin
            check("alu_wb_rd", 64'(bus.o_wb_rd), 64'd5);
            check("alu_wb_data", bus.o_wb_data, 64'h2A);
         end
         step();
      end

      // Load with data arriving before it reaches the output slot.
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) begin
            put(1'b1, 5'd7, 64'h111);
            push(5'd7, 64'hDEAD);
         end
         if (c == 1) begin
            bus.i_d_valid_data = 1'b1;
            bus.i_memory_data  = 64'hDEAD;
         end
         @(negedge clk);
         check("early_wait", 64'(bus.o_wait), 64'd0);
         check("early_wb_en", 64'(bus.o_wb_en), 64'(c == 3));
         if (c == 3) check("early_wb_data", bus.o_wb_data, 64'hDEAD);
         if (c == 4) check("early_ld_full", 64'(dut.ld_full), 64'd0);
         step();
      end

      // Late load data: wait cycles 3-5, write in 6, following entry in 7.
      for (int c = 0; c < 9; c++) begin
         idle();
         if (c == 0) begin
            put(1'b1, 5'd9, 64'h333);
            push(5'd9, 64'hBEEF);
         end
         if (c == 1) begin
            put(1'b0, 5'd10, 64'h444);
            push(5'd10, 64'h444);
         end
         if (c == 5) begin
            bus.i_d_valid_data = 1'b1;
            bus.i_memory_data  = 64'hBEEF;
         end
         @(negedge clk);
         check("late_wait", 64'(bus.o_wait), 64'(c >= 3 && c <= 5));
         check("late_wb_en", 64'(bus.o_wb_en), 64'(c == 6 || c == 7));
         if (c >= 3 && c <= 6) check("late_hold_rd", 64'(bus.o_rd_addr), 64'd9);
         if (c == 6) check("late_wb_data", bus.o_wb_data, 64'hBEEF);
         if (c == 7) check("late_next_rd", 64'(bus.o_wb_rd), 64'd10);
         step();
      end

      // Stall two cycles while A sits at the output; order A, B, C preserved.
      for (int c = 0; c < 9; c++) begin
         logic [4:0] exp_rd;
         idle();
         if (c < 3) begin
            put(1'b0, 5'(11 + c), 64'(32'hA1 + 32'h11 * c));
            push(5'(11 + c), 64'(32'hA1 + 32'h11 * c));
         end
         if (c == 3 || c == 4) bus.i_stall = 1'b1;
         exp_rd = (c <= 5) ? 5'd11 : (c == 6) ? 5'd12 : 5'd13;
         @(negedge clk);
         check("stall_wb_en", 64'(bus.o_wb_en), 64'(c >= 3 && c <= 7));
         if (c >= 3 && c <= 7) check("stall_wb_rd", 64'(bus.o_wb_rd), 64'(exp_rd));
         step();
      end

      // Flush while a load is waiting for its data.
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 0) put(1'b1, 5'd14, 64'h999);
         if (c == 3) bus.i_flush = 1'b1;
         @(negedge clk);
         if (c == 3) check("flush_pre_wait", 64'(bus.o_wait), 64'd1);
         if (c == 4) begin
            check("flush_valid", 64'(bus.o_valid), 64'd0);
            check("flush_wait", 64'(bus.o_wait), 64'd0);
            check("flush_wb_en", 64'(bus.o_wb_en), 64'd0);
         end
         step();
      end

      // Write to x0 is suppressed.
      for (int c = 0; c < 4; c++) begin
         idle();
         if (c == 0) put(1'b0, 5'd0, 64'h55);
         @(negedge clk);
         check("zero_wb_en", 64'(bus.o_wb_en), 64'd0);
         if (c == 3) check("zero_valid", 64'(bus.o_valid), 64'd1);
         step();
      end

      // Two data pulses with no consume in between set the sticky overflow.
      for (int c = 0; c < 6; c++) begin
         idle();
         if (c == 1 || c == 2) begin
            bus.i_d_valid_data = 1'b1;
            bus.i_memory_data  = 64'(c);
         end
         @(negedge clk);
         check("ovf", 64'(bus.o_ld_overflow), 64'(c >= 3));
         step();
      end

      // Reset with a full pipeline and a full load buffer discards everything.
      for (int c = 0; c < 6; c++) begin
         idle();
         rst = 1'b0;
         if (c == 0) begin
            put(1'b1, 5'd15, 64'h0);
            bus.i_d_valid_data = 1'b1;
            bus.i_memory_data  = 64'h77;
            push(5'd15, 64'h77);
         end
         if (c == 1) put(1'b0, 5'd16, 64'h66);
         if (c == 2) put(1'b0, 5'd17, 64'h88);
         if (c == 3) rst = 1'b1;
         @(negedge clk);
         if (c == 3) begin
            check("rstm_pre_wb_en", 64'(bus.o_wb_en), 64'd1);
            check("rstm_pre_ovf", 64'(bus.o_ld_overflow), 64'd1);
         end
         if (c == 4) begin
            check("rstm_valid", 64'(bus.o_valid), 64'd0);
            check("rstm_wb_en", 64'(bus.o_wb_en), 64'd0);
            check("rstm_wait", 64'(bus.o_wait), 64'd0);
            check("rstm_wb_data", bus.o_wb_data, 64'd0);
            check("rstm_rd", 64'(bus.o_rd_addr), 64'd0);
            check("rstm_ovf", 64'(bus.o_ld_overflow), 64'd0);
            check("rstm_ld_full", 64'(dut.ld_full), 64'd0);
         end
         if (c == 5) check("rstm_after_valid", 64'(bus.o_valid), 64'd0);
         step();
      end
      rst = 1'b0;

      check("sb_leftover", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/memwb_pipe.md
# memwb_pipe

Parametrised MEM/WB pipeline register: carries write-back control, ALU result, destination register and instruction through a configurable-depth delay line. This matches data-memory latency, buffers returning load data, and produces a single resolved register-file write port. It sits between the data-memory interface and the register file. Compared with the fixed three-stage MEM/WB register, it adds:
- stall and flush support;
- per-stage valid bits;
- load-data wait handshake;
- overflow detection.

## Interface
- `DATA_W`, 64 — ALU/memory data width.
- `INST_W`, 32 — instruction width.
- `LAT`, 3 — delay-line depth in cycles (≥1).
- `i_clk` input 1 — clock. One clock; all state updates on the rising edge.
- `i_rst` input 1 — reset. Reset is synchronous and active-high.
- `i_valid` input 1 — incoming MEM-stage entry is valid.
- `i_memToReg` input 1 — write-back source is load data.
- `i_regWrite` input 1 — entry writes the register file.
- `i_alu_out` input `DATA_W` — ALU result.
- `i_rd_addr` input 5 — destination register.
- `i_inst` input `INST_W` — instruction (debug/trace).
- `i_d_valid_data` input 1 — load data valid, one-cycle pulse.
- `i_memory_data` input `DATA_W` — load data, sampled when `i_d_valid_data`=1.
- `i_stall` input 1 — external freeze.
- `i_flush` input 1 — kill all in-flight entries.
- `o_valid`, `o_memToReg`, `o_regWrite` output 1 each — output-slot fields.
- `o_alu_out` output `DATA_W`.
- `o_rd_addr` output 5.
- `o_inst` output `INST_W`.
- `o_wb_en` output 1 — register-file write enable this cycle.
- `o_wb_rd` output 5 — register-file write address (= `o_rd_addr`).
- `o_wb_data` output `DATA_W` — resolved write data.
- `o_wait` output 1 — output slot is a load whose data has not arrived; upstream must stall.
- `o_ld_overflow` output 1 — sticky: load data arrived while the buffer was already full and not being consumed.

## Operation
- **Delay line.** `LAT` slots, slot 0 … slot `LAT`-1.
  - Each slot holds {valid, memToReg, regWrite, alu_out, rd_addr, inst}.
  - The `o_*` field outputs are slot `LAT`-1 registers driven directly.
- **advance.** `advance` = !`i_stall` & !`o_wait`.
  - On advance: slot 0 takes the inputs (valid = `i_valid`), and each slot k takes slot k-1.
  - Otherwise all slots hold.
- **Flush.** `i_flush`=1 clears every slot valid bit and `ld_full` on that edge, regardless of stall or wait. Flush beats stall; data fields are don't-care.
- **Load buffer.** `ld_data` register plus `ld_full` flag.
  - Capture: `i_d_valid_data`=1 → `ld_data` ← `i_memory_data`, `ld_full` ← 1.
  - Consume: edge where advance=1 and the output slot has valid & memToReg → `ld_full` ← 0, unless a capture happens on the same edge.
  - Capture and consume on the same edge: new data stored, `ld_full` stays 1, no overflow.
  - Capture with `ld_full`=1 and no consume: data overwritten, `o_ld_overflow` ← 1. Cleared only by reset.
- **Wait.** `o_wait` = `o_valid` & `o_memToReg` & !`ld_full` (combinational from state). Wait ends the cycle after data is captured.
- **Write-back.**
  - `o_wb_en` = `o_valid` & `o_regWrite` & (`o_rd_addr`≠0) & !`o_wait`.
  - `o_wb_data` = `o_memToReg` ? `ld_data` : `o_alu_out`.
  - When `i_stall`=1 with `o_wb_en` high, the same write repeats; it is idempotent.
- **Reset.**
  - All slot fields = 0, `ld_data` = 0, `ld_full` = 0, `o_ld_overflow` = 0.
  - Hence `o_valid`/`o_wb_en`/`o_wait` = 0 and `o_wb_data` = 0.
  - Reset mid-wait or mid-stall discards everything.

## Timing
- Entry presented with advance at edge N reaches the outputs after edge N+`LAT`-1, i.e. visible in cycle N+`LAT` with no stalls. Each stall or wait cycle adds one.
- Throughput: one entry per cycle when no waits occur.
- Load data may arrive any cycle from entry into slot 0 up to while the load sits in the output slot.
- At most one load may be outstanding ahead of the buffer. Violations set `o_ld_overflow`.
- `o_wait` has a combinational path only from internal registers, never from inputs.

## Structure
- Package `memwb_pkg`:
  - `memwb_slot_t` struct (valid, memToReg, regWrite, alu_out, rd_addr, inst), parametrised via `DATA_W`/`INST_W` localparams;
  - default `LAT` constant;
  - `REG_ZERO` = 5'd0.
- Sub-module `memwb_ld_buf`: `ld_data`, `ld_full` and overflow logic. Interface: capture, consume, flush; outputs data, full, overflow.
- The delay line is a generate loop of `memwb_slot_t` registers in the top module.

## Test plan
- **ALU op, `LAT`=3.** `i_valid`=1, regWrite=1, `i_alu_out`=0x2A, rd=5 at cycle 0 → `o_wb_en`=1, `o_wb_rd`=5, `o_wb_data`=0x2A in cycle 3 only.
- **Load, data before output.** Load rd=7 at cycle 0; `i_d_valid_data` pulse with 0xDEAD at cycle 1 → no `o_wait`; cycle 3 `o_wb_data`=0xDEAD, `ld_full`=0 afterwards.
- **Late data.** Load at cycle 0, data 0xBEEF at cycle 5 → `o_wait`=1 in cycles 3–5 with `o_wb_en`=0 and slots frozen; cycle 6 `o_wb_en`=1, data 0xBEEF; the following entry emerges at cycle 7.
- **Stall and flush.** Entries A, B, C back-to-back; `i_stall`=1 for 2 cycles → outputs hold, order preserved. Then `i_flush`=1 during a wait → next cycle `o_valid`=0, `o_wait`=0.
- **Zero register and overflow.** rd=0 regWrite=1 → `o_wb_en`=0. Two `i_d_valid_data` pulses with no consume between → `o_ld_overflow`=1, latched until `i_rst`=1.
- **Reset mid-operation.** Pipeline full with `ld_full`=1; assert `i_rst` one cycle → all outputs 0 next cycle.
